// File: rtl/mips_multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS main controller: states, opcodes,
// ALU-control codes, PC-source and ALU-B-source selects.
package mips_multicycle_controller_pkg;

   typedef enum logic [3:0] {
      S_FETCH      = 4'd0,
      S_DECODE     = 4'd1,
      S_MEM_ADDR   = 4'd2,
      S_MEM_READ   = 4'd3,
      S_MEM_WB     = 4'd4,
      S_MEM_WRITE  = 4'd5,
      S_EXECUTE    = 4'd6,
      S_R_COMPLETE = 4'd7,
      S_BRANCH     = 4'd8,
      S_JUMP       = 4'd9
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_J     = 6'd2;

   localparam logic [1:0] ALU_ADD   = 2'b00;
   localparam logic [1:0] ALU_SUB   = 2'b01;
   localparam logic [1:0] ALU_FUNCT = 2'b10;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   localparam logic [1:0] SRCB_REG    = 2'b00;
   localparam logic [1:0] SRCB_FOUR   = 2'b01;
   localparam logic [1:0] SRCB_IMM    = 2'b10;
   localparam logic [1:0] SRCB_IMM_SH = 2'b11;

endpackage

// File: rtl/mips_multicycle_controller_if.sv
// Control bundle between the main controller and the multicycle datapath.
// The controller (master) reads the opcode and drives every control line.
interface mips_multicycle_controller_if;
   logic [5:0] OPCODE;
   logic       PCWriteCond;
   logic       PCWrite;
   logic       IorD;
   logic       R_wbar;
   logic       MemToReg;
   logic       IRWrite;
   logic [1:0] PCSrc;
   logic [1:0] AluOp;
   logic       AluSrcA;
   logic [1:0] AluSrcB;
   logic       RegWrite;
   logic       RegDst;

   modport master (
      input  OPCODE,
      output PCWriteCond, PCWrite, IorD, R_wbar, MemToReg, IRWrite,
             PCSrc, AluOp, AluSrcA, AluSrcB, RegWrite, RegDst
   );

   modport slave (
      output OPCODE,
      input  PCWriteCond, PCWrite, IorD, R_wbar, MemToReg, IRWrite,
             PCSrc, AluOp, AluSrcA, AluSrcB, RegWrite, RegDst
   );
endinterface

// File: rtl/mips_multicycle_controller.sv
// Main control FSM of the multicycle MIPS datapath (Moore machine).
//
//   state        | meaning
//   -------------+----------------------------------------------
//   FETCH        | read instruction at PC, load IR, PC <= PC + 4
//   DECODE       | read registers, precompute branch target
//   MEM_ADDR     | ALUOut <= A + sign-extended offset
//   MEM_READ     | read data memory at ALUOut into MDR
//   MEM_WB       | write MDR to rt
//   MEM_WRITE    | write B to data memory at ALUOut
//   EXECUTE      | R-type ALU operation on A, B
//   R_COMPLETE   | write ALUOut to rd
//   BRANCH       | compare A, B; PC <= target when equal
//   JUMP         | PC <= {PC[31:28], IR[25:0], 00}
//
// Encodings 10-15 are unreachable; if ever entered they fall back to FETCH
// with all outputs at their idle values.
module mips_multicycle_controller
   import mips_multicycle_controller_pkg::*;
(
   input  logic CLK,
   input  logic RESET,
   mips_multicycle_controller_if.master ctl
);

   // Power-up value lets the FSM run in simulation without a reset pulse.
   state_t state = S_FETCH;

   // State register with synchronous reset taking priority over every transition.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state <= S_FETCH;
      end else begin
         case (state)
            S_FETCH:  state <= S_DECODE;
            S_DECODE: begin
               case (ctl.OPCODE)
                  OP_LW, OP_SW: state <= S_MEM_ADDR;
                  OP_RTYPE:     state <= S_EXECUTE;
                  OP_BEQ:       state <= S_BRANCH;
                  OP_J:         state <= S_JUMP;
                  default:      state <= S_FETCH;
               endcase
            end
            S_MEM_ADDR: begin
               if (ctl.OPCODE == OP_LW)      state <= S_MEM_READ;
               else if (ctl.OPCODE == OP_SW) state <= S_MEM_WRITE;
               else                          state <= S_FETCH;
            end
            S_MEM_READ:   state <= S_MEM_WB;
            S_MEM_WB:     state <= S_FETCH;
            S_MEM_WRITE:  state <= S_FETCH;
            S_EXECUTE:    state <= S_R_COMPLETE;
            S_R_COMPLETE: state <= S_FETCH;
            S_BRANCH:     state <= S_FETCH;
            S_JUMP:       state <= S_FETCH;
            default:      state <= S_FETCH;
         endcase
      end
   end

   // Output decode from the state register only; R_wbar idles high so memory
   // is never written outside MEM_WRITE.
   always_comb begin
      ctl.PCWriteCond = 1'b0;
      ctl.PCWrite     = 1'b0;
      ctl.IorD        = 1'b0;
      ctl.R_wbar      = 1'b1;
      ctl.MemToReg    = 1'b0;
      ctl.IRWrite     = 1'b0;
      ctl.PCSrc       = PCSRC_ALU;
      ctl.AluOp       = ALU_ADD;
      ctl.AluSrcA     = 1'b0;
      ctl.AluSrcB     = SRCB_REG;
      ctl.RegWrite    = 1'b0;
      ctl.RegDst      = 1'b0;
      case (state)
         S_FETCH: begin
            ctl.IRWrite = 1'b1;
            ctl.AluSrcB = SRCB_FOUR;
            ctl.PCWrite = 1'b1;
         end
         S_DECODE: begin
            ctl.AluSrcB = SRCB_IMM_SH;
         end
         S_MEM_ADDR: begin
            ctl.AluSrcA = 1'b1;
            ctl.AluSrcB = SRCB_IMM;
         end
         S_MEM_READ: begin
            ctl.IorD = 1'b1;
         end
         S_MEM_WB: begin
            ctl.RegWrite = 1'b1;
            ctl.MemToReg = 1'b1;
         end
         S_MEM_WRITE: begin
            ctl.R_wbar = 1'b0;
            ctl.IorD   = 1'b1;
         end
         S_EXECUTE: begin
            ctl.AluSrcA = 1'b1;
            ctl.AluOp   = ALU_FUNCT;
         end
         S_R_COMPLETE: begin
            ctl.RegWrite = 1'b1;
            ctl.RegDst   = 1'b1;
         end
         S_BRANCH: begin
            ctl.AluSrcA     = 1'b1;
            ctl.AluOp       = ALU_SUB;
            ctl.PCWriteCond = 1'b1;
            ctl.PCSrc       = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctl.PCWrite = 1'b1;
            ctl.PCSrc   = PCSRC_JUMP;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed bench for the multicycle MIPS controller: a per-cycle vector table
// of {RESET, OPCODE, expected outputs} plus hand-written reset corner cases.
module tb_mips_multicycle_controller;

   logic CLK = 1'b0;
   logic RESET;

   mips_multicycle_controller_if ctl_if ();

   mips_multicycle_controller dut (
      .CLK   (CLK),
      .RESET (RESET),
      .ctl   (ctl_if.master)
   );

   always #5 CLK = ~CLK;

   // Packed output order:
   // {PCWriteCond, PCWrite, IorD, R_wbar, MemToReg, IRWrite,
   //  PCSrc[1:0], AluOp[1:0], AluSrcA, AluSrcB[1:0], RegWrite, RegDst}
   localparam logic [14:0] E_FETCH   = 15'b010101_00_00_0_01_00;
   localparam logic [14:0] E_DECODE  = 15'b000100_00_00_0_11_00;
   localparam logic [14:0] E_MADDR   = 15'b000100_00_00_1_10_00;
   localparam logic [14:0] E_MREAD   = 15'b001100_00_00_0_00_00;
   localparam logic [14:0] E_MWB     = 15'b000110_00_00_0_00_10;
   localparam logic [14:0] E_MWRITE  = 15'b001000_00_00_0_00_00;
   localparam logic [14:0] E_EXEC    = 15'b000100_00_10_1_00_00;
   localparam logic [14:0] E_RCOMP   = 15'b000100_00_00_0_00_11;
   localparam logic [14:0] E_BRANCH  = 15'b100100_01_01_1_00_00;
   localparam logic [14:0] E_JUMP    = 15'b010100_10_00_0_00_00;

   typedef struct {
      logic        rst;
      logic [5:0]  op;
      logic [14:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];
   int   passed = 0;
   int   total  = 0;

   function automatic logic [14:0] outs();
      return {ctl_if.PCWriteCond, ctl_if.PCWrite, ctl_if.IorD, ctl_if.R_wbar,
              ctl_if.MemToReg, ctl_if.IRWrite, ctl_if.PCSrc, ctl_if.AluOp,
              ctl_if.AluSrcA, ctl_if.AluSrcB, ctl_if.RegWrite, ctl_if.RegDst};
   endfunction

   task automatic check(input string name, input logic [14:0] exp);
      logic [14:0] got;
      got = outs();
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %b expected %b", name, got, exp);
   endtask

   // Drive inputs, take one rising edge, compare #1 later.
   task automatic step(input logic rst, input logic [5:0] op,
                       input logic [14:0] exp, input string name);
      RESET         = rst;
      ctl_if.OPCODE = op;
      @(posedge CLK);
      #1;
      check(name, exp);
   endtask

   task automatic add(input logic rst, input logic [5:0] op,
                      input logic [14:0] exp, input string name);
      vec_t v;
      v.rst = rst; v.op = op; v.exp = exp; v.name = name;
      vecs.push_back(v);
   endtask

   initial begin
      RESET         = 1'b0;
      ctl_if.OPCODE = 6'd0;
      #1;
      check("powerup_fetch", E_FETCH);

      // Each row: inputs before the edge, outputs expected after it.
      add(1, 6'd0,  E_FETCH,  "reset_fetch");
      // R-type: 0,1,6,7,0; opcode wiggles in EXECUTE are ignored
      add(0, 6'd0,  E_DECODE, "r_decode");
      add(0, 6'd0,  E_EXEC,   "r_execute");
      add(0, 6'd35, E_RCOMP,  "r_complete");
      add(0, 6'd43, E_FETCH,  "r_fetch");
      // LW: 0,1,2,3,4,0
      add(0, 6'd35, E_DECODE, "lw_decode");
      add(0, 6'd35, E_MADDR,  "lw_mem_addr");
      add(0, 6'd35, E_MREAD,  "lw_mem_read");
      add(0, 6'd43, E_MWB,    "lw_mem_wb");
      add(0, 6'd43, E_FETCH,  "lw_fetch");
      // SW: 0,1,2,5,0
      add(0, 6'd43, E_DECODE, "sw_decode");
      add(0, 6'd43, E_MADDR,  "sw_mem_addr");
      add(0, 6'd43, E_MWRITE, "sw_mem_write");
      add(0, 6'd0,  E_FETCH,  "sw_fetch");
      // BEQ: 0,1,8,0
      add(0, 6'd4,  E_DECODE, "beq_decode");
      add(0, 6'd4,  E_BRANCH, "beq_branch");
      add(0, 6'd4,  E_FETCH,  "beq_fetch");
      // J: 0,1,9,0
      add(0, 6'd2,  E_DECODE, "j_decode");
      add(0, 6'd2,  E_JUMP,   "j_jump");
      add(0, 6'd2,  E_FETCH,  "j_fetch");
      // Unknown opcode: 0,1,0
      add(0, 6'd63, E_DECODE, "unk_decode");
      add(0, 6'd63, E_FETCH,  "unk_fetch");
      // Opcode re-sampled in MEM_ADDR: LW in DECODE, R-type by MEM_ADDR -> FETCH
      add(0, 6'd35, E_DECODE, "madr_decode");
      add(0, 6'd35, E_MADDR,  "madr_mem_addr");
      add(0, 6'd0,  E_FETCH,  "madr_other_fetch");
      // LW decoded, SW seen in MEM_ADDR -> MEM_WRITE
      add(0, 6'd35, E_DECODE, "madr2_decode");
      add(0, 6'd35, E_MADDR,  "madr2_mem_addr");
      add(0, 6'd43, E_MWRITE, "madr2_mem_write");
      add(0, 6'd43, E_FETCH,  "madr2_fetch");

      foreach (vecs[i]) step(vecs[i].rst, vecs[i].op, vecs[i].exp, vecs[i].name);

      // Reset during MEM_READ returns to FETCH on the next edge.
      step(0, 6'd35, E_DECODE, "rst_mr_decode");
      step(0, 6'd35, E_MADDR,  "rst_mr_mem_addr");
      step(0, 6'd35, E_MREAD,  "rst_mr_mem_read");
      step(1, 6'd35, E_FETCH,  "rst_mr_fetch");
      // Reset held for several edges keeps FETCH.
      step(1, 6'd0,  E_FETCH,  "rst_hold_fetch");
      step(0, 6'd0,  E_DECODE, "rst_rel_decode");
      // Reset in DECODE beats the opcode transition.
      step(1, 6'd4,  E_FETCH,  "rst_decode_fetch");
      // Reset during BRANCH and JUMP.
      step(0, 6'd4,  E_DECODE, "rst_br_decode");
      step(0, 6'd4,  E_BRANCH, "rst_br_branch");
      step(1, 6'd4,  E_FETCH,  "rst_br_fetch");
      step(0, 6'd0,  E_DECODE, "post_decode");
      step(0, 6'd0,  E_EXEC,   "post_execute");
      step(1, 6'd0,  E_FETCH,  "rst_exec_fetch");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
Main control FSM of the multicycle MIPS datapath, named Controller in the design. Reads the 6-bit instruction opcode and steps through fetch, decode, execute, memory and writeback states. Drives the datapath's mux selects, register/memory/PC write enables and the ALU-control opcode. Supports R-type, LW, SW, BEQ and J.

Parameters:
none (all encodings are fixed constants in the shared package)

Ports:
CLK  input  1  system clock; all state changes on the rising edge
RESET  input  1  synchronous, active-high reset
OPCODE  input  6  instruction opcode, IR[31:26]; sampled in the DECODE and MEM_ADDR states
PCWriteCond  output  1  PC write enable, qualified by the ALU zero flag (branch)
PCWrite  output  1  unconditional PC write enable
IorD  output  1  memory address select: 0 = PC, 1 = ALUOut
R_wbar  output  1  memory direction: 1 = read, 0 = write
MemToReg  output  1  register write-data select: 0 = ALUOut, 1 = MDR
IRWrite  output  1  instruction register load enable
PCSrc  output  2  PC source: 00 = ALU result, 01 = ALUOut (branch target), 10 = jump address {PC[31:28], IR[25:0], 00}
AluOp  output  2  to ALU control: 00 = add, 01 = subtract, 10 = use funct field
AluSrcA  output  1  ALU A select: 0 = PC, 1 = register A
AluSrcB  output  2  ALU B select: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
RegWrite  output  1  register file write enable
RegDst  output  1  destination register select: 0 = rt, 1 = rd

Behaviour:
- Moore machine. Outputs depend only on the current state and are combinational from the state register.
- Any output not listed as asserted in a state is 0, except R_wbar, which is 1 in every state other than MEM_WRITE.
- RESET high at a rising CLK edge sets the state to FETCH. RESET takes priority over every transition, including mid-instruction. While in FETCH, the outputs have the FETCH values listed below.
- For simulation, the state register also initialises to FETCH, so the FSM runs even if RESET is never asserted.
- Opcodes: R-type 000000 (0), LW 100011 (35), SW 101011 (43), BEQ 000100 (4), J 000010 (2).
- States, with outputs and next state:
  - FETCH (0): R_wbar=1, IorD=0, IRWrite=1, AluSrcA=0, AluSrcB=01, AluOp=00, PCSrc=00, PCWrite=1. Next: DECODE.
  - DECODE (1): AluSrcA=0, AluSrcB=11, AluOp=00. Next depends on OPCODE: LW/SW -> MEM_ADDR, R-type -> EXECUTE, BEQ -> BRANCH, J -> JUMP, any other opcode -> FETCH (treated as a no-op).
  - MEM_ADDR (2): AluSrcA=1, AluSrcB=10, AluOp=00. Next: LW -> MEM_READ, SW -> MEM_WRITE, otherwise FETCH.
  - MEM_READ (3): R_wbar=1, IorD=1. Next: MEM_WB.
  - MEM_WB (4): RegWrite=1, MemToReg=1, RegDst=0. Next: FETCH.
  - MEM_WRITE (5): R_wbar=0, IorD=1. Next: FETCH.
  - EXECUTE (6): AluSrcA=1, AluSrcB=00, AluOp=10. Next: R_COMPLETE.
  - R_COMPLETE (7): RegWrite=1, MemToReg=0, RegDst=1. Next: FETCH.
  - BRANCH (8): AluSrcA=1, AluSrcB=00, AluOp=01, PCWriteCond=1, PCSrc=01. Next: FETCH.
  - JUMP (9): PCWrite=1, PCSrc=10. Next: FETCH.
- Instruction latency, counted as cycles from entering FETCH until FETCH is re-entered: R-type 4, LW 5, SW 4, BEQ 3, J 3, unknown opcode 2.
- The state register is 4 bits wide. Unused encodings 10-15 go to FETCH on the next edge, with all outputs at their defaults (R_wbar=1).
- OPCODE changing outside DECODE and MEM_ADDR has no effect.

Decomposition:
- Shared package holds:
  - state encodings (FETCH..JUMP)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J)
  - AluOp codes (ALU_ADD, ALU_SUB, ALU_FUNCT)
  - PCSrc codes
  - AluSrcB codes
- Single module with no sub-modules: the state register, the next-state logic and the output decode are small enough to keep together.

Test Plan:
- RESET=1 for one edge, then release -> state FETCH; PCWrite=1, IRWrite=1, R_wbar=1, AluSrcB=01, AluOp=00, PCSrc=00, all other outputs 0.
- OPCODE=0 (R-type) -> states 0,1,6,7,0. In EXECUTE: AluSrcA=1, AluSrcB=00, AluOp=10. In R_COMPLETE: RegWrite=1, RegDst=1, MemToReg=0.
- OPCODE=35 (LW) -> states 0,1,2,3,4,0. In MEM_ADDR: AluSrcB=10. In MEM_READ: IorD=1, R_wbar=1. In MEM_WB: RegWrite=1, MemToReg=1, RegDst=0.
- OPCODE=43 (SW) -> states 0,1,2,5,0. R_wbar=0 and IorD=1 only in MEM_WRITE; R_wbar=1 in every other cycle.
- OPCODE=4 (BEQ), then OPCODE=2 (J) -> BRANCH: PCWriteCond=1, AluOp=01, PCSrc=01. JUMP: PCWrite=1, PCSrc=10. Each instruction is followed by FETCH.
- OPCODE=63 (unknown) -> DECODE returns to FETCH with no RegWrite or memory write asserted. RESET asserted during MEM_READ -> FETCH on the next edge.
